// File: rtl/int_alu_pipe.sv
// ---------------------------------------------------------------------------
// int_alu_pipe
// Two-stage integer execute pipeline that sits after the integer reservation
// station. S1 registers an issued ALU uop together with its operands. The
// combinational RV32I ALU between S1 and S2 computes the result, and S2 holds
// that result on the CDB until the arbiter grants it.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous squash of every in-flight uop
//   int_rs_valid       reservation station presents an issuable uop
//   fu_alu_ready       pipe accepts a uop this cycle (combinational)
//   in_*               flattened uop fields: tags, operand selects, opcode,
//                      and operands
//   cdb_grant          arbiter accepts the current broadcast
//   cdb_*              registered broadcast outputs
// ---------------------------------------------------------------------------
module int_alu_pipe #(
   parameter int ROB_IDX = 5,
   parameter int PRF_IDX = 6,
   parameter int ARF_IDX = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               int_rs_valid,
   output logic               fu_alu_ready,
   input  logic [ROB_IDX-1:0] in_rob_id,
   input  logic [PRF_IDX-1:0] in_rd_phy,
   input  logic [ARF_IDX-1:0] in_rd_arch,
   input  logic [1:0]         in_op1_sel,
   input  logic               in_op2_sel,
   input  logic [3:0]         in_fu_opcode,
   input  logic [31:0]        in_imm,
   input  logic [31:0]        in_pc,
   input  logic [31:0]        in_rs1_value,
   input  logic [31:0]        in_rs2_value,
   input  logic               cdb_grant,
   output logic               cdb_valid,
   output logic [ROB_IDX-1:0] cdb_rob_id,
   output logic [PRF_IDX-1:0] cdb_rd_phy,
   output logic [ARF_IDX-1:0] cdb_rd_arch,
   output logic [31:0]        cdb_rd_value
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;

   logic               s1Valid_q, s1Valid_d;
   logic [ROB_IDX-1:0] s1RobId_q, s1RobId_d;
   logic [PRF_IDX-1:0] s1RdPhy_q, s1RdPhy_d;
   logic [ARF_IDX-1:0] s1RdArch_q, s1RdArch_d;
   logic [1:0]         s1Op1Sel_q, s1Op1Sel_d;
   logic               s1Op2Sel_q, s1Op2Sel_d;
   logic [3:0]         s1Opcode_q, s1Opcode_d;
   logic [31:0]        s1Imm_q, s1Imm_d;
   logic [31:0]        s1Pc_q, s1Pc_d;
   logic [31:0]        s1Rs1_q, s1Rs1_d;
   logic [31:0]        s1Rs2_q, s1Rs2_d;

   logic               s2Valid_q, s2Valid_d;
   logic [ROB_IDX-1:0] s2RobId_q, s2RobId_d;
   logic [PRF_IDX-1:0] s2RdPhy_q, s2RdPhy_d;
   logic [ARF_IDX-1:0] s2RdArch_q, s2RdArch_d;
   logic [31:0]        s2Value_q, s2Value_d;

   logic        s2Free;
   logic        s1Advance;
   logic        issue;
   logic        op1Invalid;
   logic [31:0] op1, op2;
   logic [4:0]  shamt;
   logic [31:0] aluResult;

   // S2 can take a new uop when it is empty or its broadcast is being granted
   // this cycle; ready therefore depends combinationally on cdb_grant only.
   // A uop offered during flush is dropped, which is why issue masks flush
   // while ready itself does not look at it.
   always_comb begin
      s2Free       = !s2Valid_q || cdb_grant;
      s1Advance    = s1Valid_q && s2Free;
      fu_alu_ready = !s1Valid_q || s2Free;
      issue        = int_rs_valid && fu_alu_ready && !flush;
   end

   // Operand selection and the RV32I ALU. op1_sel 3 and the unused opcodes
   // quietly yield zero rather than raising any error indication.
   always_comb begin
      op1        = 32'd0;
      op1Invalid = 1'b0;
      case (s1Op1Sel_q)
         2'd0:    op1 = 32'd0;
         2'd1:    op1 = s1Rs1_q;
         2'd2:    op1 = s1Pc_q;
         default: op1Invalid = 1'b1;
      endcase
      op2   = s1Op2Sel_q ? s1Rs2_q : s1Imm_q;
      shamt = op2[4:0];
      case (s1Opcode_q)
         OP_ADD:  aluResult = op1 + op2;
         OP_SUB:  aluResult = op1 - op2;
         OP_SLL:  aluResult = op1 << shamt;
         OP_SLT:  aluResult = {31'd0, $signed(op1) < $signed(op2)};
         OP_SLTU: aluResult = {31'd0, op1 < op2};
         OP_XOR:  aluResult = op1 ^ op2;
         OP_SRL:  aluResult = op1 >> shamt;
         OP_SRA:  aluResult = $unsigned($signed(op1) >>> shamt);
         OP_OR:   aluResult = op1 | op2;
         OP_AND:  aluResult = op1 & op2;
         default: aluResult = 32'd0;
      endcase
      if (op1Invalid) begin
         aluResult = 32'd0;
      end
   end

   // Next-state for both stages. Issue, S1->S2 transfer and S2 retirement can
   // all occur in the same cycle, giving one uop per cycle under continuous
   // grant. Writes to x0 still broadcast, but with a zero value, so the ROB
   // can complete them. Flush overrides every valid bit.
   always_comb begin
      s1Valid_d  = s1Valid_q;
      s1RobId_d  = s1RobId_q;
      s1RdPhy_d  = s1RdPhy_q;
      s1RdArch_d = s1RdArch_q;
      s1Op1Sel_d = s1Op1Sel_q;
      s1Op2Sel_d = s1Op2Sel_q;
      s1Opcode_d = s1Opcode_q;
      s1Imm_d    = s1Imm_q;
      s1Pc_d     = s1Pc_q;
      s1Rs1_d    = s1Rs1_q;
      s1Rs2_d    = s1Rs2_q;
      s2Valid_d  = s2Valid_q;
      s2RobId_d  = s2RobId_q;
      s2RdPhy_d  = s2RdPhy_q;
      s2RdArch_d = s2RdArch_q;
      s2Value_d  = s2Value_q;

      if (issue) begin
         s1Valid_d  = 1'b1;
         s1RobId_d  = in_rob_id;
         s1RdPhy_d  = in_rd_phy;
         s1RdArch_d = in_rd_arch;
         s1Op1Sel_d = in_op1_sel;
         s1Op2Sel_d = in_op2_sel;
         s1Opcode_d = in_fu_opcode;
         s1Imm_d    = in_imm;
         s1Pc_d     = in_pc;
         s1Rs1_d    = in_rs1_value;
         s1Rs2_d    = in_rs2_value;
      end else if (s1Advance) begin
         s1Valid_d = 1'b0;
      end

      if (s1Advance) begin
         s2Valid_d  = 1'b1;
         s2RobId_d  = s1RobId_q;
         s2RdPhy_d  = s1RdPhy_q;
         s2RdArch_d = s1RdArch_q;
         s2Value_d  = (s1RdArch_q == '0) ? 32'd0 : aluResult;
      end else if (cdb_grant) begin
         s2Valid_d = 1'b0;
      end

      if (flush) begin
         s1Valid_d = 1'b0;
         s2Valid_d = 1'b0;
      end
   end

   // Pipeline registers; reset empties both stages and zeroes the CDB data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q  <= 1'b0;
         s1RobId_q  <= '0;
         s1RdPhy_q  <= '0;
         s1RdArch_q <= '0;
         s1Op1Sel_q <= '0;
         s1Op2Sel_q <= 1'b0;
         s1Opcode_q <= '0;
         s1Imm_q    <= '0;
         s1Pc_q     <= '0;
         s1Rs1_q    <= '0;
         s1Rs2_q    <= '0;
         s2Valid_q  <= 1'b0;
         s2RobId_q  <= '0;
         s2RdPhy_q  <= '0;
         s2RdArch_q <= '0;
         s2Value_q  <= '0;
      end else begin
         s1Valid_q  <= s1Valid_d;
         s1RobId_q  <= s1RobId_d;
         s1RdPhy_q  <= s1RdPhy_d;
         s1RdArch_q <= s1RdArch_d;
         s1Op1Sel_q <= s1Op1Sel_d;
         s1Op2Sel_q <= s1Op2Sel_d;
         s1Opcode_q <= s1Opcode_d;
         s1Imm_q    <= s1Imm_d;
         s1Pc_q     <= s1Pc_d;
         s1Rs1_q    <= s1Rs1_d;
         s1Rs2_q    <= s1Rs2_d;
         s2Valid_q  <= s2Valid_d;
         s2RobId_q  <= s2RobId_d;
         s2RdPhy_q  <= s2RdPhy_d;
         s2RdArch_q <= s2RdArch_d;
         s2Value_q  <= s2Value_d;
      end
   end

   assign cdb_valid    = s2Valid_q;
   assign cdb_rob_id   = s2RobId_q;
   assign cdb_rd_phy   = s2RdPhy_q;
   assign cdb_rd_arch  = s2RdArch_q;
   assign cdb_rd_value = s2Value_q;

endmodule

// File: tb/tb_int_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_int_alu_pipe
// Drives int_alu_pipe with directed scenarios followed by random traffic.
// Each cycle, it compares the CDB outputs and fu_alu_ready against a
// transaction-level model: an in-order list of accepted uops, each tagged
// with its issue cycle and its arithmetically computed result.
// ---------------------------------------------------------------------------
module tb_int_alu_pipe;

   localparam int ROB_IDX = 5;
   localparam int PRF_IDX = 6;
   localparam int ARF_IDX = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               flush = 1'b0;
   logic               int_rs_valid = 1'b0;
   logic               fu_alu_ready;
   logic [ROB_IDX-1:0] in_rob_id = '0;
   logic [PRF_IDX-1:0] in_rd_phy = '0;
   logic [ARF_IDX-1:0] in_rd_arch = '0;
   logic [1:0]         in_op1_sel = '0;
   logic               in_op2_sel = 1'b0;
   logic [3:0]         in_fu_opcode = '0;
   logic [31:0]        in_imm = '0;
   logic [31:0]        in_pc = '0;
   logic [31:0]        in_rs1_value = '0;
   logic [31:0]        in_rs2_value = '0;
   logic               cdb_grant = 1'b0;
   logic               cdb_valid;
   logic [ROB_IDX-1:0] cdb_rob_id;
   logic [PRF_IDX-1:0] cdb_rd_phy;
   logic [ARF_IDX-1:0] cdb_rd_arch;
   logic [31:0]        cdb_rd_value;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   typedef struct {
      logic [ROB_IDX-1:0] rob;
      logic [PRF_IDX-1:0] phy;
      logic [ARF_IDX-1:0] arch;
      logic [31:0]        value;
      int                 issued;
   } entry_t;

   entry_t inFlight[$];

   int_alu_pipe #(.ROB_IDX(ROB_IDX), .PRF_IDX(PRF_IDX), .ARF_IDX(ARF_IDX)) dut (
      .clk(clk), .rst(rst), .flush(flush), .int_rs_valid(int_rs_valid),
      .fu_alu_ready(fu_alu_ready), .in_rob_id(in_rob_id), .in_rd_phy(in_rd_phy),
      .in_rd_arch(in_rd_arch), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
      .in_fu_opcode(in_fu_opcode), .in_imm(in_imm), .in_pc(in_pc),
      .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value),
      .cdb_grant(cdb_grant), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
      .cdb_rd_phy(cdb_rd_phy), .cdb_rd_arch(cdb_rd_arch), .cdb_rd_value(cdb_rd_value)
   );

   always #5 clk = ~clk;

   // Reference ALU built directly from the RV32I operation definitions
   function automatic logic [31:0] refAlu(input logic [1:0] sel1, input logic sel2,
                                          input logic [3:0] opc, input logic [31:0] imm,
                                          input logic [31:0] pc, input logic [31:0] rs1,
                                          input logic [31:0] rs2);
      logic [31:0] a, b;
      int sh;
      if (sel1 == 2'd3) return 32'd0;
      a  = (sel1 == 2'd0) ? 32'd0 : ((sel1 == 2'd1) ? rs1 : pc);
      b  = sel2 ? rs2 : imm;
      sh = int'(b % 32);
      case (opc)
         4'd0: return a + b;
         4'd1: return a + (~b) + 32'd1;
         4'd2: return a << sh;
         4'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd4: return ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
         4'd5: return a ^ b;
         4'd6: return a >> sh;
         4'd7: return a[31] ? ~((~a) >> sh) : (a >> sh);
         4'd8: return a | b;
         4'd9: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: observed=%h expected=%h", tag, cycle, observed, expected);
      end
   endtask

   // Drives one cycle of inputs just after the clock edge, then checks the
   // outputs mid-cycle against the model and advances the model.
   task automatic applyStimulus(input logic v, input logic g, input logic f,
                                input logic [3:0] opc, input logic [1:0] sel1,
                                input logic sel2, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [4:0] rob,
                                input logic [5:0] phy, input logic [4:0] arch);
      logic   expValid, expReady;
      entry_t e;
      int_rs_valid = v; cdb_grant = g; flush = f;
      in_fu_opcode = opc; in_op1_sel = sel1; in_op2_sel = sel2;
      in_rs1_value = rs1; in_rs2_value = rs2; in_imm = imm; in_pc = pc;
      in_rob_id = rob; in_rd_phy = phy; in_rd_arch = arch;
      @(negedge clk);
      expValid = (inFlight.size() > 0) && (cycle >= inFlight[0].issued + 2);
      expReady = (inFlight.size() < 2) || g;
      checkOutput("cdb_valid", 32'(cdb_valid), 32'(expValid));
      checkOutput("fu_alu_ready", 32'(fu_alu_ready), 32'(expReady));
      if (expValid) begin
         checkOutput("cdb_rob_id", 32'(cdb_rob_id), 32'(inFlight[0].rob));
         checkOutput("cdb_rd_phy", 32'(cdb_rd_phy), 32'(inFlight[0].phy));
         checkOutput("cdb_rd_arch", 32'(cdb_rd_arch), 32'(inFlight[0].arch));
         checkOutput("cdb_rd_value", cdb_rd_value, inFlight[0].value);
      end
      if (f) begin
         inFlight.delete();
      end else begin
         if (expValid && g) void'(inFlight.pop_front());
         if (v && expReady) begin
            e.rob    = rob;
            e.phy    = phy;
            e.arch   = arch;
            e.value  = (arch == 5'd0) ? 32'd0 : refAlu(sel1, sel2, opc, imm, pc, rs1, rs2);
            e.issued = cycle;
            inFlight.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic idle(input logic g, input logic f);
      applyStimulus(1'b0, g, f, 4'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 6'd0, 5'd0);
   endtask

   logic [3:0]  sweepOp[6]  = '{4'd7, 4'd6, 4'd3, 4'd4, 4'd1, 4'd0};
   logic [31:0] sweepExp[6] = '{32'hF8000000, 32'h08000000, 32'd1, 32'd0, 32'h7FFFFFFC, 32'h00003000};

   initial begin
      #1;
      checkOutput("reset_cdb_valid", 32'(cdb_valid), 32'd0);
      checkOutput("reset_ready", 32'(fu_alu_ready), 32'd1);
      checkOutput("reset_value", cdb_rd_value, 32'd0);
      checkOutput("reset_rob", 32'(cdb_rob_id), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single ADD with grant tied high
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 2'd1, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 6'd12, 5'd1);
      idle(1'b1, 1'b0);
      checkOutput("add_value", cdb_rd_value, 32'd12);
      checkOutput("add_valid", 32'(cdb_valid), 32'd1);
      idle(1'b1, 1'b0);
      checkOutput("add_done", 32'(cdb_valid), 32'd0);
      idle(1'b1, 1'b0);

      // ALU sweep; the final entry is an AUIPC-style PC + imm
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, sweepOp[i], (i == 5) ? 2'd2 : 2'd1, (i == 5) ? 1'b0 : 1'b1,
                       32'h80000000, 32'h00000004, 32'h00002000, 32'h00001000, 5'(i), 6'(i), 5'd4);
         idle(1'b1, 1'b0);
         checkOutput("sweep_value", cdb_rd_value, sweepExp[i]);
         idle(1'b1, 1'b0);
      end

      // Back-pressure: grant low, three offered back to back
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0, 32'(i), 32'd0, 32'd100, 32'd0, 5'(10 + i), 6'(20 + i), 5'd7);
      checkOutput("bp_ready_low", 32'(fu_alu_ready), 32'd0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);

      // Streaming: ten uops under continuous grant
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 2'd1, 1'b1, 32'($urandom), 32'($urandom), 32'd0, 32'd0,
                       5'(i), 6'(40 + i), 5'(i + 1));
      for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

      // Flush with two uops held and grant low
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1, 6'd1, 5'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b1, 32'd3, 32'd4, 32'd0, 32'd0, 5'd2, 6'd2, 5'd2);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b1);
      checkOutput("flush_valid", 32'(cdb_valid), 32'd0);
      checkOutput("flush_ready", 32'(fu_alu_ready), 32'd1);
      for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

      // Write to x0 still broadcasts, with a zero value
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 2'd1, 1'b1, 32'd3, 32'd4, 32'd0, 32'd0, 5'd9, 6'd9, 5'd0);
      idle(1'b1, 1'b0);
      checkOutput("x0_valid", 32'(cdb_valid), 32'd1);
      checkOutput("x0_value", cdb_rd_value, 32'd0);
      idle(1'b1, 1'b0);

      // Asynchronous reset in the middle of a cycle while S2 is holding
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b1, 32'd8, 32'd9, 32'd0, 32'd0, 5'd5, 6'd5, 5'd5);
      idle(1'b0, 1'b0);
      checkOutput("prereset_valid", 32'(cdb_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_valid", 32'(cdb_valid), 32'd0);
      checkOutput("async_reset_ready", 32'(fu_alu_ready), 32'd1);
      checkOutput("async_reset_value", cdb_rd_value, 32'd0);
      inFlight.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle++;

      // Random traffic: operands, selects, opcodes, grants and flushes
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                       4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom),
                       32'($urandom), ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 40)),
                       32'($urandom), 32'($urandom), 5'($urandom), 6'($urandom),
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      end
      for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
